// File: rtl/uart_rx_sampler.sv
// ==== uart_rx_sampler : strobe-driven UART RX start detect, 3-sample vote, deframing | rev 1.0 ====
`default_nettype none

module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic [4:0] AcqPerBit_i,
  input  logic       Rx_i,
  output logic [7:0] RxByte_o,
  output logic       RxValid_o,
  output logic       ParityErr_o,
  output logic       FrameErr_o,
  output logic       Busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [3:0] c_last_bit = 4'(DATA_BITS - 1);
  localparam logic       c_par_en   = (PARITY_EN != 0);
  localparam logic       c_par_odd  = (PARITY_ODD != 0);

  state_t     state_q;
  logic       rx_meta_q, rx_sync_q;
  logic [4:0] n_q, s_q;
  logic [3:0] bcnt_q;
  logic [1:0] smp_q;
  logic [7:0] shift_q, shift_d;
  logic       par_q, perr_q, armed_q;

  logic [4:0] n_clamp, m_val, m_lo, m_hi, n_last;
  logic       vote, at_vote, at_last;

  always_comb begin
    n_clamp = (AcqPerBit_i < 5'd4) ? 5'd4 : AcqPerBit_i;
    m_val   = n_q >> 1;
    m_lo    = m_val - 5'd1;
    m_hi    = m_val + 5'd1;
    n_last  = n_q - 5'd1;
    // third sample is the live synced line at s = M+1
    vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);
    at_vote = (s_q == m_hi);
    at_last = (s_q == n_last);
    shift_d = (shift_q >> 1) | ({7'd0, vote} << (DATA_BITS - 1));
  end

  assign Busy_o = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= Rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= 5'd0;
      s_q         <= 5'd0;
      bcnt_q      <= 4'd0;
      smp_q       <= 2'b00;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      armed_q     <= 1'b1;
      RxByte_o    <= 8'd0;
      RxValid_o   <= 1'b0;
      ParityErr_o <= 1'b0;
      FrameErr_o  <= 1'b0;
    end else begin
      RxValid_o <= 1'b0;
      if (AcqSig_i) begin
        if (s_q == m_lo) smp_q[0] <= rx_sync_q;
        if (s_q == m_val) smp_q[1] <= rx_sync_q;
        case (state_q)
          S_IDLE: begin
            // after a low stop (break) the line must go high before re-arming
            if (!armed_q) begin
              armed_q <= rx_sync_q;
            end else if (!rx_sync_q) begin
              state_q <= S_START;
              s_q     <= 5'd1;
              n_q     <= n_clamp;
              bcnt_q  <= 4'd0;
              shift_q <= 8'd0;
              par_q   <= 1'b0;
              perr_q  <= 1'b0;
            end
          end
          S_START: begin
            if (at_vote && vote) begin
              state_q <= S_IDLE;
              s_q     <= 5'd0;
            end else if (at_last) begin
              state_q <= S_DATA;
              s_q     <= 5'd0;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
          S_DATA: begin
            if (at_vote) begin
              shift_q <= shift_d;
              par_q   <= par_q ^ vote;
            end
            if (at_last) begin
              s_q    <= 5'd0;
              bcnt_q <= bcnt_q + 4'd1;
              if (bcnt_q == c_last_bit) state_q <= c_par_en ? S_PARITY : S_STOP;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
          S_PARITY: begin
            if (at_vote) perr_q <= vote ^ par_q ^ c_par_odd;
            if (at_last) begin
              state_q <= S_STOP;
              s_q     <= 5'd0;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
          S_STOP: begin
            if (at_vote) begin
              state_q     <= S_IDLE;
              s_q         <= 5'd0;
              armed_q     <= vote;
              RxValid_o   <= 1'b1;
              RxByte_o    <= shift_q;
              ParityErr_o <= perr_q;
              FrameErr_o  <= ~vote;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            s_q     <= 5'd0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
// ==== tb_uart_rx_sampler : frame-level reference checks for uart_rx_sampler | rev 1.0 ====
`default_nettype none

module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       acq = 1'b0;
  logic       rx  = 1'b1;
  logic [4:0] apb = 5'd16;
  logic [7:0] RxByte_o;
  logic       RxValid_o, ParityErr_o, FrameErr_o, Busy_o;

  int total = 0;
  int bad   = 0;
  int per   = 22;

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];

  always #5 clk = ~clk;

  uart_rx_sampler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .AcqSig_i(acq), .AcqPerBit_i(apb), .Rx_i(rx),
    .RxByte_o(RxByte_o), .RxValid_o(RxValid_o), .ParityErr_o(ParityErr_o),
    .FrameErr_o(FrameErr_o), .Busy_o(Busy_o)
  );

  always @(negedge clk) begin
    if (RxValid_o === 1'b1) got_q.push_back({RxByte_o, ParityErr_o, FrameErr_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // one strobe period with rx held at v; caller sits on a negedge
  task automatic strobe(input logic v);
    rx  = v;
    acq = 1'b0;
    repeat (per - 1) @(negedge clk);
    acq = 1'b1;
    @(negedge clk);
    acq = 1'b0;
  endtask

  // flip_mode: 0 none, 1 flip sample M of every bit, 2 flip one random vote sample per bit
  task automatic send_frame(input logic [7:0] data, input int n_in, input logic par_flip,
                            input logic stop, input int flip_mode);
    int   n, m, fs;
    logic bits [11];
    logic v;
    n = (n_in < 4) ? 4 : n_in;
    m = n / 2;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    bits[9]  = (^data) ^ par_flip;
    bits[10] = stop;
    apb = n_in[4:0];
    for (int k = 0; k < 11; k++) begin
      fs = (flip_mode == 1) ? m : (flip_mode == 2) ? (m - 1 + int'($urandom_range(0, 2))) : -1;
      for (int s = 0; s < n; s++) begin
        v = bits[k];
        if (s == fs) v = ~v;
        strobe(v);
        if (k == 0 && s == 0) apb = 5'($urandom_range(0, 31));
      end
    end
    apb = n_in[4:0];
    exp_q.push_back({data, par_flip, ~stop});
  endtask

  task automatic check_frames(input string tag);
    rec_t g, e;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_byte"}, {24'd0, g.b}, {24'd0, e.b});
      chk({tag, "_perr"}, {31'd0, g.pe}, {31'd0, e.pe});
      chk({tag, "_ferr"}, {31'd0, g.fe}, {31'd0, e.fe});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    int         nn;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte", {24'd0, RxByte_o}, 32'd0);
    chk("rst_valid", {31'd0, RxValid_o}, 32'd0);
    chk("rst_perr", {31'd0, ParityErr_o}, 32'd0);
    chk("rst_ferr", {31'd0, FrameErr_o}, 32'd0);
    chk("rst_busy", {31'd0, Busy_o}, 32'd0);
    rst = 1'b0;

    per = 22;
    repeat (4) strobe(1'b1);
    send_frame(8'h55, 16, 1'b0, 1'b1, 0);
    repeat (2) strobe(1'b1);
    check_frames("t1");

    strobe(1'b0);
    strobe(1'b0);
    chk("t2_busy_glitch", {31'd0, Busy_o}, 32'd1);
    repeat (16) strobe(1'b1);
    chk("t2_busy_after", {31'd0, Busy_o}, 32'd0);
    check_frames("t2");

    per = 8;
    send_frame(8'hA3, 16, 1'b0, 1'b1, 1);
    repeat (2) strobe(1'b1);
    check_frames("t3");

    send_frame(8'h0F, 16, 1'b1, 1'b1, 0);
    repeat (2) strobe(1'b1);
    check_frames("t4");

    send_frame(8'hFF, 16, 1'b0, 1'b0, 0);
    repeat (40) strobe(1'b0);
    chk("t5_busy_low", {31'd0, Busy_o}, 32'd0);
    check_frames("t5");
    repeat (3) strobe(1'b1);
    send_frame(8'h3C, 16, 1'b0, 1'b1, 0);
    repeat (2) strobe(1'b1);
    check_frames("t5_rearm");

    per = int'($urandom_range(3, 8));
    send_frame(8'h12, 5, 1'b0, 1'b1, 0);
    send_frame(8'h34, 5, 1'b0, 1'b1, 0);
    repeat (2) strobe(1'b1);
    check_frames("t6_b2b");

    send_frame(8'hC5, 2, 1'b0, 1'b1, 2);
    repeat (2) strobe(1'b1);
    check_frames("t6_clamp");

    apb = 5'd5;
    repeat (7) strobe(1'b0);
    chk("t6_busy_mid", {31'd0, Busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_byte", {24'd0, RxByte_o}, 32'd0);
    chk("t6_rst_busy", {31'd0, Busy_o}, 32'd0);
    chk("t6_rst_valid", {31'd0, RxValid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) strobe(1'b1);
    chk("t6_busy_post", {31'd0, Busy_o}, 32'd0);
    check_frames("t6_rst");

    for (int it = 0; it < 10; it++) begin
      per = int'($urandom_range(3, 10));
      nn  = int'($urandom_range(0, 20));
      d   = 8'($urandom_range(0, 255));
      send_frame(d, nn, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 2);
      repeat (2) strobe(1'b1);
      check_frames("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
